kbd_event_decoder: RTL
======================

KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter REPORT_BREAK, default 1; 1 = break events queued, 0 = break events dropped.
REQ-003 SHALL have parameter TYPEMATIC_FILTER, default 1; 1 = auto-repeat makes of the held key suppressed.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-005 rx_valid  in  1  one-cycle strobe, byte received from PS/2 receiver.
REQ-006 rx_data  in  8  received scan byte, valid with rx_valid.
REQ-007 rd_en  in  1  pop head event; ignored when FIFO empty.
REQ-008 clear_overflow  in  1  clears overflow flag.
REQ-009 ev_valid  out  1  FIFO non-empty.
REQ-010 ev_code  out  8  head event scan code (first-word fall-through).
REQ-011 ev_ext  out  1  head event had E0 prefix.
REQ-012 ev_break  out  1  head event is key release.
REQ-013 ev_upper  out  1  shift XOR caps_lock, captured at event creation.
REQ-014 mods  out  4  {caps_lock, alt, ctrl, shift}, live.
REQ-015 overflow  out  1  sticky, event dropped on full FIFO.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.

Function
REQ-017 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE_SKIP.
REQ-018 IDLE: E0->EXT; F0->BRK; E1->PAUSE_SKIP with skip counter = 7; other byte -> make event {ext=0}, stay IDLE.
REQ-019 EXT: F0->EXT_BRK; other byte -> make event {ext=1} -> IDLE.
REQ-020 BRK: any byte -> break event {ext=0} -> IDLE; EXT_BRK: any byte -> break event {ext=1} -> IDLE.
REQ-021 PAUSE_SKIP: each rx_valid decrements counter; byte consumed at count 1 returns to IDLE; no events, no modifier change.
REQ-022 Byte AA (BAT pass) or FA (ACK) in IDLE SHALL be discarded.
REQ-023 Modifier keys (12, 59 shift; 14/E0 14 ctrl; 11/E0 11 alt) SHALL update per-key held bits, never queued; mods.shift/ctrl/alt = OR of left/right held bits.
REQ-024 Caps (58) make SHALL toggle caps_lock only if caps_held=0, then set caps_held; caps break clears caps_held; caps never queued.
REQ-025 TYPEMATIC_FILTER=1: make matching last_make {ext,code} while last_valid=1 dropped; new make loads last_make; break of last_make clears last_valid.
REQ-026 Event enters FIFO the cycle after rx_valid of its final byte; ev_valid rises that cycle if FIFO was empty.
REQ-027 Write to full FIFO dropped, overflow set; write and rd_en same cycle on full FIFO: both accepted, count unchanged.
REQ-028 Read and write same cycle on empty FIFO: write accepted, read ignored.
REQ-029 Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
REQ-030 overflow set has priority over clear_overflow in same cycle.

Reset
REQ-031 Reset SHALL force state IDLE, skip counter 0, FIFO empty (ev_valid=0, fifo_count=0), ev_* outputs 0, mods=0, caps_held=0, last_valid=0, overflow=0.
REQ-032 Reset mid-sequence (e.g. after E0 or F0) SHALL discard the partial sequence; next byte decoded from IDLE.

Structure
REQ-033 Shared package kbd_pkg SHALL hold scan constants (E0, E1, F0, AA, FA, 12, 59, 14, 11, 58), FSM state encoding, event-record width 11 bits {ext, brk, upper, code}.
REQ-034 FIFO SHALL be sub-module kbd_event_fifo (parametrised depth/width, FWFT, count output).

Verification
REQ-035 Bytes 1C, F0 1C -> events {1C,mk,upper=0}, {1C,brk}; fifo_count=2.
REQ-036 12, 1C, F0 1C, F0 12 -> mods.shift 1 then 0; 1C events upper=1; no 12 events queued.
REQ-037 58, F0 58, 1C, 58, 58, F0 58, 1C -> caps_lock=1, first 1C upper=1; held repeat 58 no toggle; caps_lock=0, second 1C upper=0.
REQ-038 E0 75, E0 75, E0 F0 75 with TYPEMATIC_FILTER=1 -> exactly {75,ext,mk}, {75,ext,brk}; E1 14 77 E1 F0 14 F0 77 -> no events, state IDLE.
REQ-039 FIFO_DEPTH=8, 9 makes, no reads -> fifo_count=8, overflow=1; clear_overflow -> 0; 8 pops -> ev_valid=0.
REQ-040 Reset asserted after E0 F0, then 1C -> single make {1C,ext=0}.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg
// Shared definitions for the PS/2 keyboard event decoder:
//   - scan-code constants for prefixes, controller replies and modifier keys
//   - decoder FSM state encoding
//   - event record layout {ext, brk, upper, code} (11 bits)
package kbd_pkg;

  // Prefix and controller-reply bytes
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;

  // Modifier scan codes (ctrl/alt are told left/right apart by the E0 prefix)
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // The Pause key sends E1 followed by seven more bytes that carry no event
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  localparam int EVENT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE_SKIP
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       upper;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo
// First-word fall-through FIFO with occupancy count.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   wr_en, wr_data   push request and data
//   rd_en            pop request (ignored when empty)
//   rd_data          head entry, valid whenever empty is low
//   empty, full      status flags
//   count            number of entries held (0..DEPTH)
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored even if a push arrives with it.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed since the head is only meaningful
  // while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// kbd_event_decoder
// Turns the raw PS/2 scan-code byte stream (set 2) into key events and
// queues them in an event FIFO. Modifier keys are tracked internally and
// never queued; Pause sequences and controller replies are swallowed.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   rx_valid, rx_data one-cycle strobe plus received scan byte
//   rd_en             pop head event
//   clear_overflow    clears the sticky overflow flag
//   ev_valid          an event is available
//   ev_code/ext/break/upper  head event fields (zero while empty)
//   mods              {caps_lock, alt, ctrl, shift}, live
//   overflow          sticky, an event was lost to a full FIFO
//   fifo_count        number of events held
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH       = 8,
  parameter int REPORT_BREAK     = 1,
  parameter int TYPEMATIC_FILTER = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rd_en,
  input  logic                          clear_overflow,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_upper,
  output logic [3:0]                    mods,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic BREAK_EN  = (REPORT_BREAK != 0);
  localparam logic FILTER_EN = (TYPEMATIC_FILTER != 0);

  dec_state_t state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;

  logic key_done;
  logic key_ext;
  logic key_brk;

  logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
  logic shift_l_nxt, shift_r_nxt, ctrl_l_nxt, ctrl_r_nxt, alt_l_nxt, alt_r_nxt;
  logic caps_held, caps_held_nxt;
  logic caps_lock, caps_lock_nxt;
  logic       last_valid, last_valid_nxt;
  logic [8:0] last_make, last_make_nxt;
  logic       last_match;

  logic       ev_req;
  kbd_event_t ev_rec;
  kbd_event_t head;
  logic       fifo_empty;
  logic       fifo_full;

  // Prefix tracking. key_done marks the byte that completes a key
  // sequence; key_ext/key_brk say which prefixes preceded it.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    key_done  = 1'b0;
    key_ext   = 1'b0;
    key_brk   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_E0) begin
            state_nxt = ST_EXT;
          end else if (rx_data == SC_F0) begin
            state_nxt = ST_BRK;
          end else if (rx_data == SC_E1) begin
            state_nxt = ST_PAUSE_SKIP;
            skip_nxt  = PAUSE_SKIP_LEN;
          end else if (rx_data != SC_BAT && rx_data != SC_ACK) begin
            key_done = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_F0) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            key_done  = 1'b1;
            key_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_done  = 1'b1;
          key_brk   = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          key_done  = 1'b1;
          key_ext   = 1'b1;
          key_brk   = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_PAUSE_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            skip_nxt  = 3'd0;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          skip_nxt  = 3'd0;
        end
      endcase
    end
  end

  assign last_match = last_valid && (last_make == {key_ext, rx_data});

  // Completed key sequences either update modifier state or become an
  // event request. upper is taken from the modifier state before this key.
  always_comb begin
    shift_l_nxt    = shift_l;
    shift_r_nxt    = shift_r;
    ctrl_l_nxt     = ctrl_l;
    ctrl_r_nxt     = ctrl_r;
    alt_l_nxt      = alt_l;
    alt_r_nxt      = alt_r;
    caps_held_nxt  = caps_held;
    caps_lock_nxt  = caps_lock;
    last_valid_nxt = last_valid;
    last_make_nxt  = last_make;
    ev_req         = 1'b0;
    ev_rec.ext     = key_ext;
    ev_rec.brk     = key_brk;
    ev_rec.upper   = (shift_l | shift_r) ^ caps_lock;
    ev_rec.code    = rx_data;
    if (key_done) begin
      if (rx_data == SC_LSHIFT) begin
        shift_l_nxt = !key_brk;
      end else if (rx_data == SC_RSHIFT) begin
        shift_r_nxt = !key_brk;
      end else if (rx_data == SC_CTRL) begin
        if (key_ext) ctrl_r_nxt = !key_brk;
        else         ctrl_l_nxt = !key_brk;
      end else if (rx_data == SC_ALT) begin
        if (key_ext) alt_r_nxt = !key_brk;
        else         alt_l_nxt = !key_brk;
      end else if (rx_data == SC_CAPS) begin
        // Holding caps auto-repeats its make; only the first one toggles.
        if (key_brk) begin
          caps_held_nxt = 1'b0;
        end else begin
          if (!caps_held) caps_lock_nxt = !caps_lock;
          caps_held_nxt = 1'b1;
        end
      end else if (key_brk) begin
        if (last_match) last_valid_nxt = 1'b0;
        ev_req = BREAK_EN;
      end else begin
        ev_req         = !(FILTER_EN && last_match);
        last_make_nxt  = {key_ext, rx_data};
        last_valid_nxt = 1'b1;
      end
    end
  end

  // Decoder and modifier state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      skip_cnt   <= 3'd0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      ctrl_l     <= 1'b0;
      ctrl_r     <= 1'b0;
      alt_l      <= 1'b0;
      alt_r      <= 1'b0;
      caps_held  <= 1'b0;
      caps_lock  <= 1'b0;
      last_valid <= 1'b0;
      last_make  <= 9'd0;
    end else begin
      state      <= state_nxt;
      skip_cnt   <= skip_nxt;
      shift_l    <= shift_l_nxt;
      shift_r    <= shift_r_nxt;
      ctrl_l     <= ctrl_l_nxt;
      ctrl_r     <= ctrl_r_nxt;
      alt_l      <= alt_l_nxt;
      alt_r      <= alt_r_nxt;
      caps_held  <= caps_held_nxt;
      caps_lock  <= caps_lock_nxt;
      last_valid <= last_valid_nxt;
      last_make  <= last_make_nxt;
    end
  end

  // A lost event wins over a simultaneous clear so it is never missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ev_req && fifo_full && !rd_en) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ev_req),
    .wr_data (ev_rec),
    .rd_en   (rd_en),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = ev_valid ? head.code  : 8'h00;
  assign ev_ext   = ev_valid ? head.ext   : 1'b0;
  assign ev_break = ev_valid ? head.brk   : 1'b0;
  assign ev_upper = ev_valid ? head.upper : 1'b0;
  assign mods     = {caps_lock, alt_l | alt_r, ctrl_l | ctrl_r, shift_l | shift_r};

endmodule
